// File: rtl/iir_sos_cascade_tdm.sv
// Time-multiplexed cascade of N_SOS Direct Form I biquads.
// One shared multiplier and one accumulator serve the input gain, the five
// taps and the write-back of every section, followed by the output gain.
//
// Handshake: a sample is taken on a rising edge where in_valid && in_ready
// && !clear_state. in_ready is high exactly while the block is idle, which
// is also the only time cfg_we and clear_state are honoured. out_valid is a
// single-cycle strobe (no backpressure); Filt_Out holds between strobes.
module iir_sos_cascade_tdm #(
    parameter int N_SOS  = 4,
    parameter int WI_IN  = 3,
    parameter int WF_IN  = 7,
    parameter int WI_A   = 2,
    parameter int WF_A   = 8,
    parameter int WI_B   = 2,
    parameter int WF_B   = 8,
    parameter int WI_G   = 5,
    parameter int WF_G   = 11,
    parameter int WI_OUT = 8,
    parameter int WF_OUT = 18,
    parameter int CFG_W  = 16
) (
    input  logic                         CLK,
    input  logic                         nReset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WI_IN+WF_IN-1:0]       input_sample,
    input  logic                         cfg_we,
    input  logic [$clog2(8*N_SOS+1)-1:0] cfg_addr,
    input  logic [CFG_W-1:0]             cfg_data,
    input  logic                         clear_state,
    output logic                         out_valid,
    output logic [WI_OUT+WF_OUT-1:0]     Filt_Out,
    output logic                         overFlow,
    output logic [2:0]                   dbg_state
);

    localparam int W_A   = WI_A + WF_A;
    localparam int W_B   = WI_B + WF_B;
    localparam int W_G   = WI_G + WF_G;
    localparam int W_OUT = WI_OUT + WF_OUT;
    // Common coefficient format: widest integer part and widest fraction.
    localparam int WI_C  = (WI_A > WI_B) ? ((WI_A > WI_G) ? WI_A : WI_G)
                                         : ((WI_B > WI_G) ? WI_B : WI_G);
    localparam int WF_C  = (WF_A > WF_B) ? ((WF_A > WF_G) ? WF_A : WF_G)
                                         : ((WF_B > WF_G) ? WF_B : WF_G);
    localparam int W_C   = WI_C + WF_C;
    localparam int SH_A  = WF_C - WF_A;
    localparam int SH_B  = WF_C - WF_B;
    localparam int SH_G  = WF_C - WF_G;
    // Product has fraction WF_OUT+WF_C; the accumulator adds 3 guard bits.
    localparam int W_P   = W_OUT + W_C;
    localparam int W_ACC = WI_OUT + WI_C + 3 + WF_OUT + WF_C;
    // Width after dropping the extra product fraction bits.
    localparam int W_T   = W_ACC - WF_C;
    localparam int AW    = $clog2(8*N_SOS+1);
    localparam int SW    = (N_SOS > 1) ? $clog2(N_SOS) : 1;

    localparam logic [AW-1:0]  ADDR_GOUT = AW'(8*N_SOS);
    localparam logic [SW-1:0]  SEC_LAST  = SW'(N_SOS-1);
    localparam logic [W_B-1:0] B_ONE     = W_B'(1 << WF_B);
    localparam logic [W_G-1:0] G_ONE     = W_G'(1 << WF_G);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAIN  = 3'd1,
        S_MAC   = 3'd2,
        S_WB    = 3'd3,
        S_OGAIN = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t state, state_nx;
    logic [SW-1:0] sec;
    logic [2:0]    term;
    logic          accept;
    logic          cfg_wr;
    logic          clr;
    logic          q_used;

    // Coefficient store
    logic signed [W_B-1:0] b0_m [N_SOS];
    logic signed [W_B-1:0] b1_m [N_SOS];
    logic signed [W_B-1:0] b2_m [N_SOS];
    logic signed [W_A-1:0] a1_m [N_SOS];
    logic signed [W_A-1:0] a2_m [N_SOS];
    logic signed [W_G-1:0] g_sec [N_SOS];
    logic signed [W_G-1:0] g_out;
    logic [SW-1:0]         cfg_sec;

    // History: word 4k+0 = w1, 4k+1 = w2, 4k+2 = y1, 4k+3 = y2
    logic signed [W_OUT-1:0] hist [4*N_SOS];

    // Datapath
    logic signed [W_OUT-1:0] x_in;
    logic signed [W_OUT-1:0] x_reg;
    logic signed [W_OUT-1:0] w_reg;
    logic signed [W_OUT-1:0] res_reg;
    logic signed [W_OUT-1:0] data_op;
    logic signed [W_C-1:0]   coef_op;
    logic                    term_neg;
    logic signed [W_P-1:0]   product;
    logic signed [W_ACC-1:0] product_ext;
    logic signed [W_ACC-1:0] acc;
    logic signed [W_ACC-1:0] q_in;
    logic signed [W_T-1:0]   q_trunc;
    logic signed [W_OUT-1:0] q_val;
    logic                    q_sat;
    logic                    unused_bits;

    assign dbg_state   = state;
    assign cfg_sec     = SW'(cfg_addr >> 3);
    assign x_in        = W_OUT'($signed(input_sample)) <<< (WF_OUT - WF_IN);
    assign product     = W_P'(data_op) * W_P'(coef_op);
    assign product_ext = W_ACC'(product);
    assign unused_bits = ^{cfg_data, q_in[WF_C-1:0]};

    // State register
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and idle-only strobes
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        cfg_wr   = 1'b0;
        clr      = 1'b0;
        q_used   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                cfg_wr   = cfg_we;
                clr      = clear_state;
                accept   = in_valid & ~clear_state;
                if (accept) state_nx = S_GAIN;
            end
            S_GAIN: begin
                q_used   = 1'b1;
                state_nx = S_MAC;
            end
            S_MAC: begin
                if (term == 3'd4) state_nx = S_WB;
            end
            S_WB: begin
                q_used   = 1'b1;
                state_nx = (sec == SEC_LAST) ? S_OGAIN : S_GAIN;
            end
            S_OGAIN: begin
                q_used   = 1'b1;
                state_nx = S_OUT;
            end
            S_OUT: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Section index and tap counter
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            sec  <= '0;
            term <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    sec  <= '0;
                    term <= '0;
                end
                S_GAIN:  term <= '0;
                S_MAC:   term <= term + 3'd1;
                S_WB:    sec  <= sec + SW'(1);
                default: ;
            endcase
        end
    end

    // Coefficient writes; reset loads an identity filter
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < N_SOS; i++) begin
                b0_m[i]  <= B_ONE;
                b1_m[i]  <= '0;
                b2_m[i]  <= '0;
                a1_m[i]  <= '0;
                a2_m[i]  <= '0;
                g_sec[i] <= G_ONE;
            end
            g_out <= G_ONE;
        end else if (cfg_wr) begin
            if (cfg_addr == ADDR_GOUT) begin
                g_out <= cfg_data[W_G-1:0];
            end else if (cfg_addr < ADDR_GOUT) begin
                case (cfg_addr[2:0])
                    3'd0:    b0_m[cfg_sec]  <= cfg_data[W_B-1:0];
                    3'd1:    b1_m[cfg_sec]  <= cfg_data[W_B-1:0];
                    3'd2:    b2_m[cfg_sec]  <= cfg_data[W_B-1:0];
                    3'd3:    a1_m[cfg_sec]  <= cfg_data[W_A-1:0];
                    3'd4:    a2_m[cfg_sec]  <= cfg_data[W_A-1:0];
                    3'd5:    g_sec[cfg_sec] <= cfg_data[W_G-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Operand select for the shared multiplier, coefficients aligned to WF_C
    always_comb begin
        data_op  = x_reg;
        coef_op  = W_C'(g_sec[sec]) <<< SH_G;
        term_neg = 1'b0;
        if (state == S_OGAIN) begin
            coef_op = W_C'(g_out) <<< SH_G;
        end else if (state == S_MAC) begin
            case (term)
                3'd0: begin
                    data_op = w_reg;
                    coef_op = W_C'(b0_m[sec]) <<< SH_B;
                end
                3'd1: begin
                    data_op = hist[{sec, 2'd0}];
                    coef_op = W_C'(b1_m[sec]) <<< SH_B;
                end
                3'd2: begin
                    data_op = hist[{sec, 2'd1}];
                    coef_op = W_C'(b2_m[sec]) <<< SH_B;
                end
                3'd3: begin
                    data_op  = hist[{sec, 2'd2}];
                    coef_op  = W_C'(a1_m[sec]) <<< SH_A;
                    term_neg = 1'b1;
                end
                default: begin
                    data_op  = hist[{sec, 2'd3}];
                    coef_op  = W_C'(a2_m[sec]) <<< SH_A;
                    term_neg = 1'b1;
                end
            endcase
        end
    end

    // Quantiser: floor to WF_OUT, then saturate to the data range
    always_comb begin
        q_in    = (state == S_WB) ? acc : product_ext;
        q_trunc = q_in[W_ACC-1:WF_C];
        q_val   = q_trunc[W_OUT-1:0];
        q_sat   = 1'b0;
        if (q_trunc[W_T-1:W_OUT-1] != {(W_T-W_OUT+1){q_trunc[W_T-1]}}) begin
            q_sat = 1'b1;
            q_val = q_trunc[W_T-1] ? {1'b1, {(W_OUT-1){1'b0}}}
                                   : {1'b0, {(W_OUT-1){1'b1}}};
        end
    end

    // Section data registers and accumulator
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            x_reg   <= '0;
            w_reg   <= '0;
            acc     <= '0;
            res_reg <= '0;
        end else begin
            case (state)
                S_IDLE:  if (accept) x_reg <= x_in;
                S_GAIN: begin
                    w_reg <= q_val;
                    acc   <= '0;
                end
                S_MAC:   acc <= term_neg ? (acc - product_ext) : (acc + product_ext);
                S_WB:    x_reg <= q_val;
                S_OGAIN: res_reg <= q_val;
                default: ;
            endcase
        end
    end

    // History shift on write-back; cleared on request while idle
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 4*N_SOS; i++) hist[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 4*N_SOS; i++) hist[i] <= '0;
        end else if (state == S_WB) begin
            hist[{sec, 2'd1}] <= hist[{sec, 2'd0}];
            hist[{sec, 2'd0}] <= w_reg;
            hist[{sec, 2'd3}] <= hist[{sec, 2'd2}];
            hist[{sec, 2'd2}] <= q_val;
        end
    end

    // Output register, valid strobe and sticky saturation flag
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            Filt_Out  <= '0;
            out_valid <= 1'b0;
            overFlow  <= 1'b0;
        end else begin
            out_valid <= (state == S_OUT);
            if (state == S_OUT) Filt_Out <= res_reg;
            if (clr) begin
                overFlow <= 1'b0;
            end else if (q_used && q_sat) begin
                overFlow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_sos_cascade_tdm.sv
// Bench for iir_sos_cascade_tdm: randomized samples and coefficient writes,
// expected outputs from a sample-by-sample difference-equation model.
module tb_iir_sos_cascade_tdm;

    localparam int     N_SOS   = 4;
    localparam int     LAT     = 7*N_SOS + 2;
    localparam longint OUT_MAX = 33554431;
    localparam longint OUT_MIN = -33554432;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        nReset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  input_sample;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        clear_state;
    logic        out_valid;
    logic [25:0] Filt_Out;
    logic        overFlow;
    logic [2:0]  dbg_state;

    always #5 CLK = ~CLK;

    longint cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    iir_sos_cascade_tdm dut (
        .CLK          (CLK),
        .nReset       (nReset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_sample (input_sample),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .clear_state  (clear_state),
        .out_valid    (out_valid),
        .Filt_Out     (Filt_Out),
        .overFlow     (overFlow),
        .dbg_state    (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // {overflow, Filt_Out} expected per accepted sample, plus acceptance cycle
    logic [26:0] exp_q[$];
    longint      exp_t_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint mb0[N_SOS], mb1[N_SOS], mb2[N_SOS], ma1[N_SOS], ma2[N_SOS], mg[N_SOS];
    longint mgo;
    longint mw1[N_SOS], mw2[N_SOS], my1[N_SOS], my2[N_SOS];
    bit     movf;

    function automatic longint sx(input logic [15:0] d, input int w);
        longint v;
        v = longint'(d) & ((64'sd1 << w) - 1);
        if (v >= (64'sd1 << (w - 1))) v = v - (64'sd1 << w);
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N_SOS; k++) begin
            mw1[k] = 0; mw2[k] = 0; my1[k] = 0; my2[k] = 0;
        end
        movf = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_SOS; k++) begin
            mb0[k] = 256; mb1[k] = 0; mb2[k] = 0; ma1[k] = 0; ma2[k] = 0; mg[k] = 2048;
        end
        mgo = 2048;
        model_clear();
    endtask

    task automatic model_cfg(input int addr, input logic [15:0] d);
        int k;
        if (addr == 8*N_SOS) begin
            mgo = sx(d, 16);
        end else if (addr < 8*N_SOS) begin
            k = addr / 8;
            case (addr % 8)
                0: mb0[k] = sx(d, 10);
                1: mb1[k] = sx(d, 10);
                2: mb2[k] = sx(d, 10);
                3: ma1[k] = sx(d, 10);
                4: ma2[k] = sx(d, 10);
                5: mg[k]  = sx(d, 16);
                default: ;
            endcase
        end
    endtask

    // value carries 'sh' extra fraction bits beyond 18: floor, then clamp
    task automatic qsat(input longint v, input int sh, output longint r);
        r = v >>> sh;
        if (r > OUT_MAX) begin
            r = OUT_MAX; movf = 1;
        end else if (r < OUT_MIN) begin
            r = OUT_MIN; movf = 1;
        end
    endtask

    task automatic model_run(input logic [9:0] s, output logic [26:0] e);
        longint x, w, y, a;
        x = sx({6'b0, s}, 10) * 2048;
        for (int k = 0; k < N_SOS; k++) begin
            qsat(mg[k] * x, 11, w);
            a = mb0[k]*w + mb1[k]*mw1[k] + mb2[k]*mw2[k] - ma1[k]*my1[k] - ma2[k]*my2[k];
            qsat(a, 8, y);
            mw2[k] = mw1[k]; mw1[k] = w;
            my2[k] = my1[k]; my1[k] = y;
            x = y;
        end
        qsat(mgo * x, 11, y);
        e = {movf, y[25:0]};
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic push_expected(input logic [9:0] s);
        logic [26:0] e;
        model_run(s, e);
        exp_q.push_back(e);
        exp_t_q.push_back(cyc);
    endtask

    task automatic send(input logic [9:0] s);
        wait_ready();
        in_valid = 1; input_sample = s;
        @(posedge CLK); #1;
        in_valid = 0;
        push_expected(s);
    endtask

    task automatic cfg(input int addr, input logic [15:0] d);
        wait_ready();
        cfg_we = 1; cfg_addr = 6'(addr); cfg_data = d;
        @(posedge CLK); #1;
        cfg_we = 0;
        model_cfg(addr, d);
    endtask

    task automatic send_cfg(input logic [9:0] s, input int addr, input logic [15:0] d);
        wait_ready();
        in_valid = 1; input_sample = s;
        cfg_we = 1; cfg_addr = 6'(addr); cfg_data = d;
        @(posedge CLK); #1;
        in_valid = 0; cfg_we = 0;
        model_cfg(addr, d);
        push_expected(s);
    endtask

    task automatic clear_with_sample();
        wait_ready();
        clear_state = 1; in_valid = 1; input_sample = 10'($urandom_range(0, 1023));
        @(posedge CLK); #1;
        clear_state = 0; in_valid = 0;
        model_clear();
        check("overflow_after_clear", overFlow, 0);
        check("clear_blocks_sample", in_ready, 1);
    endtask

    function automatic logic [15:0] rand_coef();
        if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 65535));
        return 16'($urandom_range(0, 511)) - 16'd256;
    endfunction

    // ---------------- scoreboard monitor ----------------
    task automatic monitor();
        logic [26:0] e;
        longint      t;
        logic        prev = 0;
        forever begin
            @(negedge CLK);
            if (!nReset) begin
                prev = 0;
            end else begin
                if (out_valid) begin
                    check("out_valid_single_cycle", prev, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: Filt_Out 0x%0h with no sample pending at %0t", Filt_Out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        t = exp_t_q.pop_front();
                        check("filt_out", Filt_Out, e[25:0]);
                        check("overflow", overFlow, e[26]);
                        check("latency", 32'(cyc - t), LAT);
                        check("in_ready_with_out_valid", in_ready, 1);
                    end
                end
                prev = out_valid;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d expected outputs pending", exp_q.size());
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] s;
        nReset = 0; in_valid = 0; input_sample = '0; cfg_we = 0;
        cfg_addr = '0; cfg_data = '0; clear_state = 0;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_out_valid", out_valid, 0);
        check("reset_filt_out", Filt_Out, 0);
        check("reset_overflow", overFlow, 0);
        check("reset_in_ready", in_ready, 1);
        nReset = 1;
        @(posedge CLK); #1;
        check("release_in_ready", in_ready, 1);

        // identity after reset
        send(10'h040);
        send(10'h380);

        // impulse through section 0: b=(0.25,0.5,0.25), a1=-0.5
        cfg(0, 16'h0040); cfg(1, 16'h0080); cfg(2, 16'h0040);
        cfg(3, 16'h0380); cfg(4, 16'h0000);
        send(10'h080);
        repeat (4) send(10'h000);

        // saturation: large gains in sections 0 and 1, flag stays set
        cfg(5, 16'h7800); cfg(13, 16'h7800);
        send(10'h1FF);
        send(10'h000);
        clear_with_sample();

        // back to identity; reserved and out-of-range addresses do nothing
        cfg(0, 16'h0100); cfg(1, 0); cfg(2, 0); cfg(3, 0);
        cfg(5, 16'h0800); cfg(13, 16'h0800);
        cfg(6, 0); cfg(7, 0); cfg(14, 0); cfg(33, 0); cfg(63, 0);
        repeat (3) send(10'($urandom_range(0, 1023)));

        // write and sample in the same idle cycle: sample sees the new g_N
        send_cfg(10'h040, 32, 16'h1000);
        send(10'h0C0);
        cfg(32, 16'h0800);

        // write while busy is ignored
        send(10'($urandom_range(0, 1023)));
        repeat (4) @(posedge CLK);
        #1;
        cfg_we = 1; cfg_addr = 6'd0; cfg_data = 16'h0000;
        check("busy_in_ready", in_ready, 0);
        @(posedge CLK); #1;
        cfg_we = 0;
        send(10'($urandom_range(0, 1023)));

        // randomized mix of writes, clears and samples
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 9);
            s  = 10'($urandom_range(0, 1023));
            if (op < 3)       cfg($urandom_range(0, 63), rand_coef());
            else if (op == 3) clear_with_sample();
            else if (op == 4) send_cfg(s, $urandom_range(0, 63), rand_coef());
            else              send(s);
        end

        // reset in the middle of a sample
        send(10'($urandom_range(0, 1023)));
        repeat (9) @(posedge CLK);
        #1;
        nReset = 0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_filt_out", Filt_Out, 0);
        check("midreset_overflow", overFlow, 0);
        check("midreset_in_ready", in_ready, 1);
        exp_q.delete();
        exp_t_q.delete();
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nReset = 1;
        @(posedge CLK); #1;
        check("after_midreset_in_ready", in_ready, 1);
        repeat (40) @(posedge CLK);
        #1;
        send(10'($urandom_range(0, 1023)));
        send(10'h040);

        // drain
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
